// File: rtl/dct_tile_scheduler.sv
// Walks a square image tile by tile, feeds each 8x8 window to the shared dct2d,
// then streams the 64 captured coefficients to the coefficient RAM.
module dct_tile_scheduler #(
  parameter int N       = 10,
  parameter int IMG_DIM = 128,
  parameter int DCT_LAT = 5,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic [N*64-1:0]   win_out,
  input  logic [N*64-1:0]   win_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data
);

  localparam int TILES = IMG_DIM / 8;
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int LW    = (DCT_LAT > 1) ? $clog2(DCT_LAT) : 1;
  localparam logic [TW-1:0] LAST_T = TW'(TILES - 1);
  localparam logic [LW-1:0] LAST_W = LW'(DCT_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_STORE, S_DONE} state_t;

  state_t             state_q;
  logic [6:0]         cnt_q;
  logic [LW-1:0]      lat_q;
  logic [TW-1:0]      tx_q, ty_q;
  logic [TW-1:0]      tx_d, ty_d;
  logic               last_tile;
  logic [5:0]         k_nxt;
  logic [5:0]         fslot;
  logic               busy_q, done_q, wr_en_q;
  logic [ADDR_W-1:0]  rd_addr_q, wr_addr_q;
  logic [N-1:0]       wr_data_q;
  logic [N*64-1:0]    win_q;
  logic [N-1:0]       coef_q [64];

  // (8*ty + r)*IMG_DIM + 8*tx + c; every term fits ADDR_W, so no overflow.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [TW-1:0] ty,
                                                  input logic [TW-1:0] tx,
                                                  input logic [5:0]    k);
    logic [ADDR_W-1:0] a;
    a = (ADDR_W'(ty) * ADDR_W'(8) + ADDR_W'(k[5:3])) * ADDR_W'(IMG_DIM)
        + ADDR_W'(tx) * ADDR_W'(8) + ADDR_W'(k[2:0]);
    return a;
  endfunction

  always_comb begin
    last_tile = (tx_q == LAST_T) && (ty_q == LAST_T);
    k_nxt     = 6'(cnt_q + 7'd1);
    fslot     = 6'(cnt_q - 7'd1);
    tx_d      = tx_q;
    ty_d      = ty_q;
    if (tx_q == LAST_T) begin
      tx_d = '0;
      ty_d = ty_q + 1'b1;
    end else begin
      tx_d = tx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
      tx_q      <= '0;
      ty_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      win_q     <= '0;
      for (int unsigned i = 0; i < 64; i++) coef_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            busy_q    <= 1'b1;
            tx_q      <= '0;
            ty_q      <= '0;
            cnt_q     <= '0;
            rd_addr_q <= elem_addr('0, '0, 6'd0);
          end
        end
        S_FETCH: begin
          // Read data trails its address by one cycle, hence slot cnt-1.
          if (cnt_q != 7'd0) win_q[fslot*N +: N] <= rd_data;
          if (cnt_q < 7'd63) rd_addr_q <= elem_addr(ty_q, tx_q, k_nxt);
          if (cnt_q == 7'd64) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            lat_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_WAIT: begin
          if (lat_q == LAST_W) begin
            for (int unsigned i = 0; i < 64; i++) coef_q[i] <= win_in[i*N +: N];
            state_q   <= S_STORE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= elem_addr(ty_q, tx_q, 6'd0);
            wr_data_q <= win_in[N-1:0];
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_STORE: begin
          if (cnt_q == 7'd63) begin
            wr_en_q <= 1'b0;
            cnt_q   <= '0;
            if (last_tile) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_FETCH;
              tx_q      <= tx_d;
              ty_q      <= ty_d;
              rd_addr_q <= elem_addr(ty_d, tx_d, 6'd0);
            end
          end else begin
            cnt_q     <= cnt_q + 7'd1;
            wr_addr_q <= elem_addr(ty_q, tx_q, k_nxt);
            wr_data_q <= coef_q[k_nxt];
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_addr = rd_addr_q;
  assign win_out = win_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_dct_tile_scheduler.sv
// Scoreboard bench for dct_tile_scheduler on a 16x16 image with a 1-cycle pixel RAM
// and a behavioural dct2d stand-in (identity or negation).
module tb_dct_tile_scheduler;
  localparam int N    = 10;
  localparam int IMG  = 16;
  localparam int LAT  = 5;
  localparam int AW   = 14;
  localparam int NPIX = IMG * IMG;
  localparam int T    = IMG / 8;
  localparam int PASS_CYC = T * T * (129 + LAT) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, wr_en;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [N-1:0]    rd_data = '0;
  logic [N-1:0]    wr_data;
  logic [N*64-1:0] win_out, win_in;

  always #5 clk = ~clk;

  dct_tile_scheduler #(.N(N), .IMG_DIM(IMG), .DCT_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .win_out(win_out), .win_in(win_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  logic [N-1:0] pram [NPIX];
  logic [N-1:0] oram [NPIX];
  always @(posedge clk) rd_data <= pram[rd_addr[7:0]];

  // dct2d stand-in: result is readable on the LAT-th cycle of a stable window.
  bit              neg_mode = 1'b0;
  logic [N*64-1:0] pipe [LAT-1];
  function automatic logic [N*64-1:0] xform(input logic [N*64-1:0] w, input bit ng);
    logic [N*64-1:0] o;
    for (int k = 0; k < 64; k++) o[k*N +: N] = ng ? (~w[k*N +: N] + 1'b1) : w[k*N +: N];
    return o;
  endfunction
  always @(posedge clk) begin
    pipe[0] <= xform(win_out, neg_mode);
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign win_in = pipe[LAT-2];

  int checks = 0, failures = 0;
  int cyc = 0, s_cyc = 0, d_cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct packed {logic [AW-1:0] a; logic [N-1:0] d;} wr_t;
  wr_t           exp_wq[$];
  logic [AW-1:0] exp_rq[$];
  int            pass_w = 0, pass_done = 0, done_cnt = 0, rd_idx = 0;
  bit            first_rd = 1'b0;
  logic [AW-1:0] last_rd = '0;
  logic [AW-1:0] rdlog [NPIX];
  logic [N-1:0]  win9 = '0;

  // Monitor: pops the scoreboards whenever the DUT presents a write or a new read.
  always @(negedge clk) begin
    wr_t e;
    logic [AW-1:0] ea;
    if (rst_n) begin
      if (wr_en) begin
        oram[wr_addr[7:0]] = wr_data;
        if (pass_w == 0) win9 = win_out[9*N +: N];
        pass_w++;
        if (exp_wq.size() == 0) chk(1'b0, "unexpected_write", longint'(wr_addr), -1);
        else begin
          e = exp_wq.pop_front();
          chk(wr_addr == e.a, "wr_addr", longint'(wr_addr), longint'(e.a));
          chk(wr_data == e.d, "wr_data", longint'($signed(wr_data)), longint'($signed(e.d)));
        end
      end
      if (busy && (first_rd || rd_addr != last_rd)) begin
        first_rd = 1'b0;
        last_rd  = rd_addr;
        if (rd_idx < NPIX) rdlog[rd_idx] = rd_addr;
        rd_idx++;
        if (exp_rq.size() == 0) chk(1'b0, "unexpected_read", longint'(rd_addr), -1);
        else begin
          ea = exp_rq.pop_front();
          chk(rd_addr == ea, "rd_addr", longint'(rd_addr), longint'(ea));
        end
      end
      if (done) begin
        done_cnt++;
        pass_done = 1;
        d_cyc = cyc;
        chk(busy == 1'b0, "busy_at_done", longint'(busy), 0);
      end
    end
  end

  task automatic build(input bit ng);
    wr_t e;
    int a, v;
    exp_wq.delete();
    exp_rq.delete();
    for (int ty = 0; ty < T; ty++)
      for (int tx = 0; tx < T; tx++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            a = (8*ty + r) * IMG + 8*tx + c;
            v = $signed(pram[a]);
            exp_rq.push_back(AW'(a));
            e.a = AW'(a);
            e.d = N'(ng ? -v : v);
            exp_wq.push_back(e);
          end
  endtask

  task automatic fill_random();
    for (int a = 0; a < NPIX; a++) pram[a] = N'(int'($urandom_range(0, 1022)) - 511);
    for (int a = 0; a < NPIX; a++) oram[a] = '0;
  endtask

  task automatic kick();
    first_rd = 1'b1;
    rd_idx = 0;
    pass_w = 0;
    pass_done = 0;
    @(posedge clk); #1 start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit extra);
    for (int i = 0; i < 3000 && pass_done == 0; i++) begin
      start = extra && (i == 9 || i == 299);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk(pass_done == 1, "done_timeout", pass_done, 1);
  endtask

  task automatic check_pass_ident();
    int bad = 0;
    chk(d_cyc - s_cyc == PASS_CYC, "latency", d_cyc - s_cyc, PASS_CYC);
    chk(pass_w == NPIX, "write_count", pass_w, NPIX);
    chk(exp_wq.size() == 0, "wq_drained", exp_wq.size(), 0);
    for (int a = 0; a < NPIX; a++) if (oram[a] !== pram[a]) bad++;
    chk(bad == 0, "oram_eq", bad, 0);
  endtask

  initial begin
    int dc0, pw;
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0, pw;
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(busy == 1'b0, "rst_busy", longint'(busy), 0);
    chk(done == 1'b0, "rst_done", longint'(done), 0);
    chk(wr_en == 1'b0, "rst_wr_en", longint'(wr_en), 0);
    chk(win_out == '0, "rst_win_nonzero", longint'(win_out != '0), 0);
    chk(rd_addr == '0, "rst_rd_addr", longint'(rd_addr), 0);
    chk(wr_addr == '0, "rst_wr_addr", longint'(wr_addr), 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk(busy == 1'b0, "start_in_reset_ignored", longint'(busy), 0);

    // Pass A: ramp image, identity transform, address sequence.
    neg_mode = 1'b0;
    for (int a = 0; a < NPIX; a++) begin pram[a] = N'(a % 512); oram[a] = '0; end
    build(1'b0);
    kick();
    wait_done(1'b0);
    check_pass_ident();
    chk(rdlog[64] == 8, "tile01_first", longint'(rdlog[64]), 8);
    chk(rdlog[71] == 15, "tile01_row0_end", longint'(rdlog[71]), 15);
    chk(rdlog[72] == 24, "tile01_row1", longint'(rdlog[72]), 24);
    chk(rdlog[128] == 128, "tile10_first", longint'(rdlog[128]), 128);
    chk(win9 == pram[17], "slot9_addr17", longint'(win9), longint'(pram[17]));
    repeat (3) @(posedge clk);
    #1;
    chk(busy == 1'b0, "idle_after_done", longint'(busy), 0);

    // Pass B: negating transform with start pulses mid-pass.
    neg_mode = 1'b1;
    fill_random();
    pram[0] = N'(-3);
    pram[1] = N'(100);
    build(1'b1);
    dc0 = done_cnt;
    kick();
    wait_done(1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk(done_cnt - dc0 == 1, "single_done", done_cnt - dc0, 1);
    chk(pass_w == NPIX, "write_count_restart", pass_w, NPIX);
    chk(busy == 1'b0, "no_restart", longint'(busy), 0);
    chk($signed(oram[0]) == 3, "neg_m3", longint'($signed(oram[0])), 3);
    chk($signed(oram[1]) == -100, "neg_100", longint'($signed(oram[1])), -100);

    // Pass C: reset pulse during the STORE of tile 2 aborts the pass.
    neg_mode = 1'b0;
    fill_random();
    build(1'b0);
    dc0 = done_cnt;
    kick();
    for (int i = 0; i < 3000 && pass_w < 138; i++) begin @(posedge clk); #1; end
    chk(pass_w >= 138, "reach_tile2_store", pass_w, 138);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_wq.delete();
    exp_rq.delete();
    pw = pass_w;
    @(negedge clk);
    chk(wr_en == 1'b0, "wr_en_after_reset", longint'(wr_en), 0);
    chk(busy == 1'b0, "busy_after_reset", longint'(busy), 0);
    repeat (700) @(posedge clk);
    #1;
    chk(done_cnt == dc0, "no_done_after_abort", done_cnt - dc0, 0);
    chk(pass_w == pw, "no_writes_after_abort", pass_w - pw, 0);

    // Pass D: fresh full pass after the abort.
    fill_random();
    build(1'b0);
    kick();
    wait_done(1'b0);
    check_pass_ident();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dct_tile_scheduler.md
Name: dct_tile_scheduler

Overview:
- Sequences the 2-D 8x8 DCT core (dct2d) over a full square image held in a pixel RAM.
- Walks the image tile by tile in raster order. For each tile it gathers 64 pixels into the packed window bus, holds that window for the DCT latency, captures the coefficient window, then streams the 64 coefficients to an output RAM.
- Sits between the image buffers and the single shared dct2d instance; it is the only driver of dct2d data_in.

Parameters:
- N, 10, pixel/coefficient width in bits (must match dct2d N)
- IMG_DIM, 128, image side in pixels; must be a multiple of 8 and at least 8
- DCT_LAT, 5, clk cycles from a stable data_in to a valid data_out on dct2d; must be at least 1
- ADDR_W, 14, RAM address width; must be at least log2(IMG_DIM*IMG_DIM)

Ports:
- clk  in  1  system clock; everything is on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a full-image pass; ignored while busy=1
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last coefficient write of the image
- rd_addr  out  ADDR_W  pixel RAM read address; rd_data is valid exactly 1 cycle later
- rd_data  in  N  signed pixel from the pixel RAM
- win_out  out  N*64  packed window to dct2d data_in; element k is at [k*N +: N], k = 8*r + c
- win_in  in  N*64  packed coefficients from dct2d data_out; same packing
- wr_en  out  1  coefficient RAM write strobe
- wr_addr  out  ADDR_W  coefficient RAM write address
- wr_data  out  N  signed coefficient

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM goes to IDLE. busy, done, wr_en, rd_addr, wr_addr, wr_data, win_out and all counters are 0.
- Reset asserted mid-pass aborts the pass: no done pulse, no further writes, and no partial state survives.
- Address of element (r,c) in tile (ty,tx): (8*ty + r)*IMG_DIM + 8*tx + c. Tiles go tx-fastest; elements go c-fastest. Address arithmetic is unsigned and width-safe.
- IDLE: on start=1, go to FETCH with ty=tx=0. busy rises the next cycle.
- FETCH lasts 65 cycles.
  - Cycles 0..63 issue rd_addr for k=0..63.
  - Cycles 1..64 write rd_data into win_out slot k-1.
  - Only the slot being written changes; no other win_out bits change during FETCH.
- WAIT lasts DCT_LAT cycles. win_out is held stable.
  - On the last WAIT cycle, win_in is latched into an internal 64xN coefficient buffer.
- STORE lasts 64 cycles. Each cycle drives wr_en=1 with wr_addr for k=0..63 (same address formula) and wr_data = buffer slot k.
  - wr_en is 0 in every other state.
- After STORE:
  - If the tile is not the last, advance tx, wrapping to 0 and incrementing ty at IMG_DIM/8, then go to FETCH.
  - If it is the last tile (ty = tx = IMG_DIM/8 - 1), go to DONE.
- DONE lasts 1 cycle: done=1 and busy=0 in that cycle, then IDLE.
- Per-tile cost is 129 + DCT_LAT cycles, with no overlap between tiles.
- A full pass takes (IMG_DIM/8)^2 * (129 + DCT_LAT) + 1 cycles from the cycle after start to the done pulse.
- Whenever not FETCH and not STORE, rd_addr holds its last value and wr_addr/wr_data hold theirs.
- start arriving in the same cycle as done is ignored. A new start is accepted only while in IDLE.
- Signed values pass through unchanged: no truncation, extension or rounding.

Test Plan:
- Use a 1-cycle-latency RAM model. After reset, outputs busy=0, done=0, wr_en=0, win_out=0 are required. A start pulse while rst_n=0 must be ignored.
- IMG_DIM=16, DCT_LAT=5, pixel RAM[a]=a mod 512, dct2d replaced by an identity model (data_out=data_in delayed 5 cycles):
  - output RAM must equal the input RAM at all 256 addresses;
  - done must come exactly 4*134+1 = 537 cycles after start.
- Same setup, check the address sequence:
  - tile (0,1) reads begin at address 8, then 9..15, then 24;
  - tile (1,0) reads begin at address 128;
  - the window slot for rd_addr 17 is k=9.
- Use a dct2d model that outputs the window with every element negated (keep values within N bits) and a pixel of -3 at address 0. This requires wr_data = 3 at wr_addr 0, and a pixel of 100 must produce -100, with signs preserved.
- Pulse start again at cycles 10 and 300 of a busy pass: exactly one done pulse and exactly 256 writes, with no restart.
- Drop rst_n low during the STORE of tile 2 for 1 cycle:
  - wr_en must be 0 from the next cycle;
  - no done pulse;
  - a fresh start must then complete a full, correct pass.
